alu: RTL
========

# alu

8-bit execution unit for the 65C02 microcode core. It sits between the register file read port and its write port. It combines the register operand with a memory/data-bus operand and produces the registered write-back byte. It also owns the processor status register P. Decimal-mode ADC/SBC take one extra cycle for BCD adjust, so the block has a small sequencer and a done/busy handshake.

## Interface
Parameters:
- `P_RESET`, 8'h34: reset value of P (I=1, D=0, bits 5/4 set).

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  reset. Asynchronous assert, active-low. Clears all state.
- `rdy`  in  1  global advance enable. When low, all state is frozen, including the FSM, OUT, P and done.
- `start`  in  1  launches the operation in `op`. Sampled only when `rdy`=1 and the FSM is IDLE.
- `op`  in  4  operation select (encodings in package).
- `flag_en`  in  1  when 1, the op's flag subset is written to P at completion.
- `R`  in  8  register operand (from register file DO).
- `M`  in  8  memory/data operand.
- `p_load`  in  1  direct write of P from `p_in` (PLP/RTI/SEx/CLx).
- `p_in`  in  8  new P value. Bits 5 and 4 are forced to 1 on load.
- `OUT`  out  8  registered result (to register file DI).
- `P`  out  8  status register {N,V,1,1,D,I,Z,C}.
- `busy`  out  1  high while in ADJ state.
- `done`  out  1  one-`rdy`-cycle pulse marking OUT/P updated.

## Operation
- op: 0 ORA, 1 AND, 2 EOR, 3 ADC, 4 PASSM, 5 PASSR, 6 CMP, 7 SBC, 8 ASL, 9 ROL, A LSR, B ROR, C INC (R+1), D DEC (R-1), E BIT, F NOP.
- Carry in: ADC/SBC/ROL/ROR use P.C. CMP uses a fixed carry of 1.
- SBC and CMP compute R + ~M + cin, in 9 bits. C is bit 8.
- V (ADC/SBC) = (R[7]~^Mop[7]) & (R[7]^sum[7]), where Mop is M for ADC and ~M for SBC.
- Flag subsets:
  - logic, PASS, INC, DEC: N, Z.
  - ADC, SBC: N, V, Z, C.
  - CMP and shifts: N, Z, C.
  - BIT: N=M[7], V=M[6], Z=((R&M)==0).
  - NOP: none. OUT is unchanged for NOP.
- FSM states and transitions:
  - IDLE, on accepted start with non-decimal op: OUT and flags are written at that edge, done=1 the next cycle, stay IDLE.
  - IDLE, on accepted ADC/SBC with P.D=1: the binary sum, V, nibble half-carry and carry are latched internally. Go to ADJ, busy=1.
  - ADJ (next `rdy` edge): apply BCD adjust, write OUT/flags, done=1, return to IDLE.
- BCD adjust rules:
  - ADC: add 6 to the low nibble if it exceeds 9 or there was a half-carry. Add 0x60 if the high result exceeds 9 or there was a carry; in that case C=1.
  - SBC: subtract 6 on a low borrow and 0x60 on a high borrow. C = no borrow.
  - N and Z come from the adjusted result (65C02 behaviour). V comes from the binary sum.
- `start` while busy is ignored; no queueing.
- `p_load` is accepted in any state. If it coincides with an ALU flag write at the same edge, `p_load` wins for all bits.
- `flag_en`=0 suppresses the P update; OUT is still written.

## Timing
- Reset: OUT=8'h00, P=P_RESET, state IDLE, busy=0, done=0. Reset mid-ADJ aborts the op with no OUT/P write.
- Latency, binary ops: 1 cycle from the accepted start to valid OUT/P (done high).
- Latency, decimal ADC/SBC: 2 cycles.
- `rdy` low while in ADJ holds the state. done stays at its last value until the next `rdy` edge.
- `R`, `M` and `op` are sampled only at the accepting edge. Changes during ADJ have no effect.
- Back-to-back: a new start is accepted in the same cycle done is high (FSM already IDLE).

## Structure
- Package `alu_pkg`:
  - op code localparams.
  - P bit indices (N=7, V=6, D=3, I=2, Z=1, C=0).
  - `P_RESET_DEFAULT`.
- Sub-module `bcd_adjust`: combinational. Inputs: binary sum, half-carry, carry, sub flag. Outputs: adjusted byte and C. Instantiated once in ADJ-state datapath.

## Test plan
- Binary ADC: R=0x50, M=0x50, C=0, D=0 -> OUT=0xA0, N=1, V=1, Z=0, C=0; done 1 cycle after start.
- Decimal ADC: R=0x58, M=0x46, C=1, D=1 -> busy 1 cycle, then OUT=0x05, C=1, Z=0, N=0.
- Decimal SBC: R=0x12, M=0x21, C=1, D=1 -> OUT=0x91, C=0, N=1.
- CMP and BIT: CMP with R=0x40, M=0x40 -> Z=1, C=1, N=0. BIT with R=0x0F, M=0xC0 -> N=1, V=1, Z=1.
- Hazards:
  - rdy=0 for 3 cycles during ADJ -> OUT/P frozen, result appears on first rdy edge.
  - p_load p_in=0x00 coincident with ADC completion -> P=0x30.
- Reset: rst_n low during ADJ -> P=0x34, OUT=0x00, busy=0 immediately (asynchronously). The subsequent start is accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 65C02 execution unit: op codes, P bit positions, FSM state, decimal context.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [3:0] OP_ORA  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_EOR  = 4'h2;
  localparam logic [3:0] OP_ADC  = 4'h3;
  localparam logic [3:0] OP_PASM = 4'h4;
  localparam logic [3:0] OP_PASR = 4'h5;
  localparam logic [3:0] OP_CMP  = 4'h6;
  localparam logic [3:0] OP_SBC  = 4'h7;
  localparam logic [3:0] OP_ASL  = 4'h8;
  localparam logic [3:0] OP_ROL  = 4'h9;
  localparam logic [3:0] OP_LSR  = 4'hA;
  localparam logic [3:0] OP_ROR  = 4'hB;
  localparam logic [3:0] OP_INC  = 4'hC;
  localparam logic [3:0] OP_DEC  = 4'hD;
  localparam logic [3:0] OP_BIT  = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  // P = {N,V,1,1,D,I,Z,C}
  localparam int PB_N = 7;
  localparam int PB_V = 6;
  localparam int PB_D = 3;
  localparam int PB_I = 2;
  localparam int PB_Z = 1;
  localparam int PB_C = 0;

  localparam logic [7:0] P_RESET_DEFAULT = 8'h34;
  // Bits 5 and 4 of P read as one whenever P is loaded directly.
  localparam logic [7:0] P_FIXED_ONES    = 8'h30;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ADJ  = 1'b1
  } state_t;

  // Everything the ADJ cycle needs, captured at the accepting edge so R/M/op may change freely.
  typedef struct packed {
    logic [7:0] sum;
    logic       hc;
    logic       c;
    logic       v;
    logic       sub;
    logic       flag_en;
  } dec_ctx_t;

  // Replace only the P bits selected by mask.
  function automatic logic [7:0] merge_flags(input logic [7:0] p, input logic [7:0] val,
                                             input logic [7:0] mask);
    return (p & ~mask) | (val & mask);
  endfunction

endpackage

// File: rtl/bcd_adjust.sv
// Decimal correction of a latched binary ADC/SBC sum into packed BCD plus final carry.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module bcd_adjust
  import alu_pkg::*;
(
  input  logic [7:0] sum_i,
  input  logic       hc_i,
  input  logic       c_i,
  input  logic       sub_i,
  output logic [7:0] res_o,
  output logic       c_o
);

  logic [8:0] t;

  // Low-nibble fix first; the ADC high-nibble test looks at the partially adjusted value.
  always_comb begin
    t   = {1'b0, sum_i};
    c_o = c_i;
    if (!sub_i) begin
      if ((sum_i[3:0] > 4'd9) || hc_i) begin
        t = t + 9'h006;
      end
      if ((t[8:4] > 5'd9) || c_i) begin
        t   = t + 9'h060;
        c_o = 1'b1;
      end
    end else begin
      // Carry clear means borrow; C already holds "no borrow" from the binary subtract.
      if (!hc_i) begin
        t = t - 9'h006;
      end
      if (!c_i) begin
        t = t - 9'h060;
      end
    end
    res_o = t[7:0];
  end

endmodule

// File: rtl/alu.sv
// 65C02 execution unit: combines R and M into registered OUT, owns status register P.
// Latency: 1 cycle for binary ops, 2 cycles for decimal ADC/SBC (one ADJ cycle).
// Backpressure: rdy=0 freezes all state; start is ignored while busy, nothing is queued.
module alu
  import alu_pkg::*;
#(
  parameter logic [7:0] P_RESET = P_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       start,
  input  logic [3:0] op,
  input  logic       flag_en,
  input  logic [7:0] R,
  input  logic [7:0] M,
  input  logic       p_load,
  input  logic [7:0] p_in,
  output logic [7:0] OUT,
  output logic [7:0] P,
  output logic       busy,
  output logic       done
);

  state_t     state_q;
  logic [7:0] out_q;
  logic [7:0] p_q;
  logic       done_q;
  dec_ctx_t   ctx_q;

  logic       sub_op;
  logic       cin_eff;
  logic [7:0] m_op;
  logic [8:0] sum9;
  logic       hc;
  logic       v_bin;
  logic       dec_start;

  logic [7:0] res_d;
  logic [7:0] fval_d;
  logic [7:0] fmask_d;

  logic [7:0] adj_res;
  logic       adj_c;
  logic [7:0] fval_adj;

  // Shared 9-bit adder: ADC uses M, SBC/CMP add the complement so C is "no borrow".
  always_comb begin
    sub_op    = (op == OP_SBC) || (op == OP_CMP);
    m_op      = sub_op ? ~M : M;
    cin_eff   = (op == OP_CMP) ? 1'b1 : p_q[PB_C];
    sum9      = {1'b0, R} + {1'b0, m_op} + {8'd0, cin_eff};
    hc        = R[4] ^ m_op[4] ^ sum9[4];
    v_bin     = (R[7] ~^ m_op[7]) & (R[7] ^ sum9[7]);
    dec_start = ((op == OP_ADC) || (op == OP_SBC)) && p_q[PB_D];
  end

  // Binary result and the flag subset each op is allowed to touch.
  always_comb begin
    res_d   = out_q;
    fval_d  = 8'h00;
    fmask_d = 8'h00;
    unique case (op)
      OP_ORA:  begin res_d = R | M; fmask_d = 8'h82; end
      OP_AND:  begin res_d = R & M; fmask_d = 8'h82; end
      OP_EOR:  begin res_d = R ^ M; fmask_d = 8'h82; end
      OP_PASM: begin res_d = M;     fmask_d = 8'h82; end
      OP_PASR: begin res_d = R;     fmask_d = 8'h82; end
      OP_INC:  begin res_d = R + 8'd1; fmask_d = 8'h82; end
      OP_DEC:  begin res_d = R - 8'd1; fmask_d = 8'h82; end
      OP_ADC, OP_SBC: begin
        res_d        = sum9[7:0];
        fmask_d      = 8'hC3;
        fval_d[PB_V] = v_bin;
        fval_d[PB_C] = sum9[8];
      end
      OP_CMP: begin
        res_d        = sum9[7:0];
        fmask_d      = 8'h83;
        fval_d[PB_C] = sum9[8];
      end
      OP_ASL: begin res_d = {R[6:0], 1'b0};       fmask_d = 8'h83; fval_d[PB_C] = R[7]; end
      OP_ROL: begin res_d = {R[6:0], p_q[PB_C]};  fmask_d = 8'h83; fval_d[PB_C] = R[7]; end
      OP_LSR: begin res_d = {1'b0, R[7:1]};       fmask_d = 8'h83; fval_d[PB_C] = R[0]; end
      OP_ROR: begin res_d = {p_q[PB_C], R[7:1]};  fmask_d = 8'h83; fval_d[PB_C] = R[0]; end
      OP_BIT: begin
        res_d        = R & M;
        fmask_d      = 8'hC2;
        fval_d[PB_N] = M[7];
        fval_d[PB_V] = M[6];
        fval_d[PB_Z] = ((R & M) == 8'h00);
      end
      default: begin res_d = out_q; fmask_d = 8'h00; end
    endcase
    if (op != OP_BIT) begin
      fval_d[PB_N] = res_d[7];
      fval_d[PB_Z] = (res_d == 8'h00);
    end
  end

  bcd_adjust u_bcd_adjust (
    .sum_i (ctx_q.sum),
    .hc_i  (ctx_q.hc),
    .c_i   (ctx_q.c),
    .sub_i (ctx_q.sub),
    .res_o (adj_res),
    .c_o   (adj_c)
  );

  // Decimal flags: N/Z from the corrected byte, V from the binary sum.
  always_comb begin
    fval_adj       = 8'h00;
    fval_adj[PB_N] = adj_res[7];
    fval_adj[PB_V] = ctx_q.v;
    fval_adj[PB_Z] = (adj_res == 8'h00);
    fval_adj[PB_C] = adj_c;
  end

  // Sequencer, result and status registers; p_load is applied last so it overrides any flag write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= 8'h00;
      p_q     <= P_RESET;
      done_q  <= 1'b0;
      ctx_q   <= '0;
    end else if (rdy) begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (dec_start) begin
              ctx_q.sum     <= sum9[7:0];
              ctx_q.hc      <= hc;
              ctx_q.c       <= sum9[8];
              ctx_q.v       <= v_bin;
              ctx_q.sub     <= (op == OP_SBC);
              ctx_q.flag_en <= flag_en;
              state_q       <= ST_ADJ;
            end else begin
              out_q  <= res_d;
              if (flag_en) begin
                p_q <= merge_flags(p_q, fval_d, fmask_d);
              end
              done_q <= 1'b1;
            end
          end
        end
        ST_ADJ: begin
          out_q <= adj_res;
          if (ctx_q.flag_en) begin
            p_q <= merge_flags(p_q, fval_adj, 8'hC3);
          end
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (p_load) begin
        p_q <= p_in | P_FIXED_ONES;
      end
    end
  end

  assign OUT  = out_q;
  assign P    = p_q;
  assign busy = (state_q == ST_ADJ);
  assign done = done_q;

endmodule
